// File: rtl/lcd_pkg.sv
`timescale 1ns / 1ps
// Shared LCD definitions: word layout, common command words, arbiter state encoding.
package lcd_pkg;

  localparam int LCD_DW     = 9;
  localparam int LCD_DC_BIT = 8;

  // Command words carry D/C = 0 in bit 8
  localparam logic [LCD_DW-1:0] LCD_CMD_SLPOUT = 9'h011;
  localparam logic [LCD_DW-1:0] LCD_CMD_DISPON = 9'h029;
  localparam logic [LCD_DW-1:0] LCD_CMD_CASET  = 9'h02A;
  localparam logic [LCD_DW-1:0] LCD_CMD_RASET  = 9'h02B;
  localparam logic [LCD_DW-1:0] LCD_CMD_RAMWR  = 9'h02C;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_OWN     = 3'b010,
    ST_RELEASE = 3'b100
  } arb_state_t;

endpackage

// File: rtl/lcd_rr_pick.sv
`timescale 1ns / 1ps
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module lcd_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  always_comb begin
    int   w_idx;
    logic w_found;
    w_idx   = 0;
    w_found = 1'b0;
    o_grant = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      for (int j = 0; j < N; j++) begin
        if (!w_found && (j == w_idx) && i_req[j]) begin
          o_grant[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
`timescale 1ns / 1ps
// Frame-locked arbiter sharing one LCD byte writer between several producers.
// Optional idle-owner watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int          NUM_REQ     = 3,
  parameter int          DW          = LCD_DW,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  init_done,
  input  logic [NUM_REQ-1:0]    req_en,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_wr_done,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  wr_en,
  output logic [DW-1:0]         wr_data,
  input  logic                  wr_done,
  output logic                  arb_err
);

  localparam int              PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0]   LAST_IDX = PW'(NUM_REQ - 1);

  arb_state_t          r_state, w_state_next;
  logic [NUM_REQ-1:0]  r_grant, w_grant_next, w_eligible, w_pick;
  logic [PW-1:0]       r_rr_ptr, w_rr_ptr_next, w_owner_idx;
  logic [DW-1:0]       w_owner_data;
  logic                w_owner_req, w_owner_done, w_release, w_timeout;

  // Before init completes only the init sequencer may win
  assign w_eligible = req_en & (init_done ? {NUM_REQ{1'b1}} : NUM_REQ'(1));

  lcd_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .i_req   (w_eligible),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick)
  );

  always_comb begin
    w_owner_idx  = '0;
    w_owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_owner_idx  = PW'(i);
        w_owner_data = req_data[i*DW +: DW];
      end
    end
  end

  assign w_owner_req  = |(req_en & r_grant);
  assign w_owner_done = |(req_done & r_grant);
  assign w_release    = (r_state == ST_OWN) && (w_owner_done || w_timeout);

`ifdef LCD_ARB_TIMEOUT_EN
  logic [23:0] r_idle_cnt;
  logic        r_arb_err;

  assign w_timeout = (r_state == ST_OWN) && !w_owner_req && !wr_done &&
                     (r_idle_cnt == TIMEOUT_CYC - 24'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idle_cnt <= '0;
      r_arb_err  <= 1'b0;
    end else begin
      // A genuine frame end on the same cycle is not an error
      r_arb_err <= w_timeout && !w_owner_done;
      if ((r_state != ST_OWN) || w_owner_req || wr_done || w_release)
        r_idle_cnt <= '0;
      else
        r_idle_cnt <= r_idle_cnt + 24'd1;
    end
  end

  assign arb_err = r_arb_err;
`else
  assign w_timeout = 1'b0;
  assign arb_err   = 1'b0 & (TIMEOUT_CYC == 24'd0);
`endif

  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_rr_ptr_next = r_rr_ptr;
    wr_en         = 1'b0;
    wr_data       = '0;
    req_wr_done   = '0;
    case (r_state)
      ST_IDLE: begin
        if (|w_pick) begin
          w_grant_next = w_pick;
          w_state_next = ST_OWN;
        end
      end
      ST_OWN: begin
        wr_en       = w_owner_req;
        wr_data     = w_owner_data;
        req_wr_done = r_grant & {NUM_REQ{wr_done}};
        if (w_release) begin
          w_state_next  = ST_RELEASE;
          w_grant_next  = '0;
          w_rr_ptr_next = (w_owner_idx == LAST_IDX) ? '0 : w_owner_idx + 1'b1;
        end
      end
      ST_RELEASE: w_state_next = ST_IDLE;
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= PW'(1);
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  assign grant = r_grant;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
`timescale 1ns / 1ps
// Self-checking bench for lcd_write_arbiter: scoreboard of expected writer words.
module tb_lcd_write_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic [2:0]  req_en, req_done, req_wr_done, grant;
  logic [26:0] req_data;
  logic        wr_en, wr_done, arb_err;
  logic [8:0]  wr_data;

  logic [2:0]  pen = '0;
  logic [2:0]  pdn = '0;
  logic [8:0]  pdata [3];
  logic        wr_done_auto = 1'b0;
  logic        wr_done_man = 1'b0;
  logic        writer_on = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q [$];

  assign req_en   = pen;
  assign req_done = pdn;
  assign req_data = {pdata[2], pdata[1], pdata[0]};
  assign wr_done  = wr_done_auto | wr_done_man;

  lcd_write_arbiter dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .init_done   (init_done),
    .req_en      (req_en),
    .req_data    (req_data),
    .req_done    (req_done),
    .req_wr_done (req_wr_done),
    .grant       (grant),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_done     (wr_done),
    .arb_err     (arb_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Byte writer model: one wr_done per presented word, every other cycle
  always @(posedge sys_clk) wr_done_auto <= writer_on && wr_en && !wr_done_auto;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      checks++;
      if ((grant & (grant - 3'd1)) != 3'd0) begin
        errors++;
        $display("FAIL grant_onehot: grant=%b required one-hot or zero", grant);
      end
      checks++;
      if (wr_en && grant == 3'd0) begin
        errors++;
        $display("FAIL wr_en_no_grant: wr_en=1 grant=%b required grant nonzero", grant);
      end
      checks++;
      if (req_wr_done !== (grant & {3{wr_done}})) begin
        errors++;
        $display("FAIL wr_done_route: req_wr_done=%b required=%b", req_wr_done, grant & {3{wr_done}});
      end
      if (wr_en && wr_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: wr_data=%h with empty scoreboard", wr_data);
        end else begin
          logic [8:0] exp_w;
          exp_w = exp_q.pop_front();
          if (wr_data !== exp_w) begin
            errors++;
            $display("FAIL write_data: wr_data=%h required=%h", wr_data, exp_w);
          end
        end
      end
    end
  end

  task automatic wait_ack(input logic [1:0] p, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge sys_clk);
      if (req_wr_done[p]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ack_timeout p%0d: got no req_wr_done, required one within 4000 clocks", p);
    end else if (grant !== (3'b001 << p)) begin
      errors++;
      $display("FAIL owner_grant p%0d: grant=%b required=%b", p, grant, 3'b001 << p);
    end
  endtask

  task automatic run_producer(input logic [1:0] p, input int nframes, input int nwords, input int base);
    bit ok;
    for (int f = 0; f < nframes; f++) begin
      for (int n = 0; n < nwords; n++) begin
        pdata[p] = 9'(base + f * nwords + n);
        pen[p]   = 1'b1;
        wait_ack(p, ok);
        if (!ok) begin
          pen[p] = 1'b0;
          return;
        end
        @(posedge sys_clk); #1;
      end
      pen[p] = 1'b0;
      pdn[p] = 1'b1;
      @(posedge sys_clk); #1;
      pdn[p] = 1'b0;
    end
  endtask

  task automatic push_frame(input int base, input int nwords);
    for (int n = 0; n < nwords; n++) exp_q.push_back(9'(base + n));
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    init_done = 1'b1;
    pen = 3'b111;
    pdata[0] = 9'h0F0; pdata[1] = 9'h1A5; pdata[2] = 9'h05A;
    repeat (3) @(posedge sys_clk);
    #1;
    checks += 5;
    if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: grant=%b required=000", grant); end
    if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: wr_en=%b required=0", wr_en); end
    if (wr_data !== 9'h000) begin errors++; $display("FAIL reset_wr_data: wr_data=%h required=000", wr_data); end
    if (req_wr_done !== 3'b000) begin errors++; $display("FAIL reset_req_wr_done: req_wr_done=%b required=000", req_wr_done); end
    if (arb_err !== 1'b0) begin errors++; $display("FAIL reset_arb_err: arb_err=%b required=0", arb_err); end
    pen = 3'b000;
    init_done = 1'b0;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_init_gate();
    pen = 3'b110;
    for (int c = 0; c < 100; c++) begin
      @(posedge sys_clk); #1;
      checks += 2;
      if (grant !== 3'b000) begin errors++; $display("FAIL init_gate_grant cyc%0d: grant=%b required=000", c, grant); end
      if (wr_en !== 1'b0) begin errors++; $display("FAIL init_gate_wr_en cyc%0d: wr_en=%b required=0", c, wr_en); end
    end
    pen = 3'b000;
  endtask

  task automatic test_init_frame();
    writer_on = 1'b0;
    exp_q.push_back(9'h011);
    pdata[0] = 9'h011;
    pen[0] = 1'b1;
    @(posedge sys_clk); #1;
    checks += 3;
    if (grant !== 3'b001) begin errors++; $display("FAIL init_grant: grant=%b required=001", grant); end
    if (wr_en !== 1'b1) begin errors++; $display("FAIL init_wr_en: wr_en=%b required=1", wr_en); end
    if (wr_data !== 9'h011) begin errors++; $display("FAIL init_wr_data: wr_data=%h required=011", wr_data); end
    // frame end coinciding with the byte acknowledge
    wr_done_man = 1'b1;
    pdn[0] = 1'b1;
    #1;
    checks++;
    if (req_wr_done !== 3'b001) begin errors++; $display("FAIL coincident_done: req_wr_done=%b required=001", req_wr_done); end
    @(posedge sys_clk); #1;
    wr_done_man = 1'b0;
    pdn[0] = 1'b0;
    pen[0] = 1'b0;
    checks += 2;
    if (grant !== 3'b000) begin errors++; $display("FAIL release_grant: grant=%b required=000", grant); end
    if (wr_en !== 1'b0) begin errors++; $display("FAIL release_wr_en: wr_en=%b required=0", wr_en); end
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (grant !== 3'b000) begin errors++; $display("FAIL idle_after_release: grant=%b required=000", grant); end
  endtask

  task automatic test_round_robin();
    init_done = 1'b1;
    writer_on = 1'b1;
    push_frame('h100, 4);
    push_frame('h180, 4);
    push_frame('h104, 4);
    fork
      run_producer(2'd1, 2, 4, 'h100);
      run_producer(2'd2, 1, 4, 'h180);
    join
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (grant !== 3'b000) begin errors++; $display("FAIL rr_idle: grant=%b required=000", grant); end
  endtask

  task automatic test_long_frame();
    push_frame(0, 640);
    push_frame('h1F0, 4);
    fork
      run_producer(2'd1, 1, 640, 0);
      begin
        repeat (5) @(posedge sys_clk);
        #1;
        run_producer(2'd2, 1, 4, 'h1F0);
      end
      begin
        repeat (60) @(posedge sys_clk);
        #1;
        pdn[2] = 1'b1;
        @(posedge sys_clk); #1;
        pdn[2] = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        checks++;
        if (grant !== 3'b010) begin errors++; $display("FAIL foreign_done: grant=%b required=010", grant); end
      end
    join
  endtask

  task automatic test_wr_done_idle();
    writer_on = 1'b0;
    @(posedge sys_clk); #1;
    wr_done_man = 1'b1;
    #1;
    checks += 2;
    if (req_wr_done !== 3'b000) begin errors++; $display("FAIL idle_wr_done: req_wr_done=%b required=000", req_wr_done); end
    if (grant !== 3'b000) begin errors++; $display("FAIL idle_grant: grant=%b required=000", grant); end
    @(posedge sys_clk); #1;
    wr_done_man = 1'b0;
  endtask

  task automatic test_hold_and_reset();
    writer_on = 1'b0;
    pdata[1] = 9'h0AA;
    pen[1] = 1'b1;
    @(posedge sys_clk); #1;
    checks++;
    if (grant !== 3'b010) begin errors++; $display("FAIL hold_grant: grant=%b required=010", grant); end
    pen[1] = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge sys_clk); #1;
      checks += 2;
      if (grant !== 3'b010) begin errors++; $display("FAIL hold_owner cyc%0d: grant=%b required=010", c, grant); end
      if (arb_err !== 1'b0) begin errors++; $display("FAIL hold_arb_err cyc%0d: arb_err=%b required=0", c, arb_err); end
    end
    pdata[1] = 9'h155;
    pen[1] = 1'b1;
    #1;
    checks += 2;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL resume_wr_en: wr_en=%b required=1", wr_en); end
    if (wr_data !== 9'h155) begin errors++; $display("FAIL resume_wr_data: wr_data=%h required=155", wr_data); end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks += 3;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL async_reset_wr_en: wr_en=%b required=0", wr_en); end
    if (grant !== 3'b000) begin errors++; $display("FAIL async_reset_grant: grant=%b required=000", grant); end
    if (wr_data !== 9'h000) begin errors++; $display("FAIL async_reset_wr_data: wr_data=%h required=000", wr_data); end
    pen = 3'b000;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    pdata[0] = '0; pdata[1] = '0; pdata[2] = '0;
    test_reset();
    test_init_gate();
    test_init_frame();
    test_round_robin();
    test_long_frame();
    test_wr_done_idle();
    test_hold_and_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d words never written, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete within 2 ms");
    $fatal(1, "timeout");
  end

endmodule
